// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths, FSM states and Booth op codes for the multiplier
package mult_pkg;

  localparam int WIDTH = 8;
  localparam int ITER  = WIDTH;
  localparam logic [3:0] LAST_COUNT = 4'(ITER - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_SUB} op_t;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_1}.
  function automatic op_t booth_op(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/add_sub_8bit.sv
// rtl/add_sub_8bit.sv - 8-bit two's complement adder/subtractor with signed overflow flag
module add_sub_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       m,
  output logic [7:0] s,
  output logic       ovr
);

  logic [7:0] b_eff;

  // m doubles as the carry-in so a - b = a + ~b + 1.
  assign b_eff = b ^ {8{m}};
  assign s     = a + b_eff + {7'd0, m};
  assign ovr   = (a[7] == b_eff[7]) && (s[7] != a[7]);

endmodule

// File: rtl/booth_mult_8bit.sv
// rtl/booth_mult_8bit.sv - sequential radix-2 Booth multiplier, signed 8x8 -> 16
module booth_mult_8bit
  import mult_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] q_reg;
  logic             q_1;
  logic [WIDTH-1:0] m_reg;
  logic [3:0]       count;

  op_t              op;
  logic [WIDTH-1:0] sum;
  logic             ovr;
  logic [WIDTH-1:0] a_next;
  logic             sign_in;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] q_shift;

  assign op = booth_op(q_reg[0], q_1);

  add_sub_8bit u_add_sub (
    .a   (a_reg),
    .b   (m_reg),
    .m   (op == OP_SUB),
    .s   (sum),
    .ovr (ovr)
  );

  // On overflow the true 9-bit result's sign is s[7]^ovr; shifting that in keeps -128 cases exact.
  always_comb begin
    a_next  = a_reg;
    sign_in = a_reg[WIDTH-1];
    if (op != OP_NOP) begin
      a_next  = sum;
      sign_in = sum[WIDTH-1] ^ ovr;
    end
    a_shift = {sign_in, a_next[WIDTH-1:1]};
    q_shift = {a_next[0], q_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_reg   <= '0;
      q_reg   <= '0;
      q_1     <= 1'b0;
      m_reg   <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg <= '0;
            q_reg <= multiplier;
            q_1   <= 1'b0;
            m_reg <= multiplicand;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_reg <= a_shift;
          q_reg <= q_shift;
          q_1   <= q_reg[0];
          count <= count + 4'd1;
          if (count == LAST_COUNT) begin
            product <= {a_shift, q_shift};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_8bit.sv
// tb/tb_booth_mult_8bit.sv - directed self-checking bench for booth_mult_8bit
module tb_booth_mult_8bit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks;
  int failures;
  int lat;
  int busy_cycles;
  int overlap;
  int pulses;

  booth_mult_8bit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge (+#1); counts edges until done is seen, bounded.
  task automatic wait_done(output int n, output int bc, output int ov);
    n  = 0;
    bc = busy ? 1 : 0;
    ov = 0;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (busy && done) ov++;
      if (busy && !done) bc++;
    end
  endtask

  task automatic run_mult(input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp, input string tag);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, busy_cycles, overlap);
    chk({tag, "_latency"}, lat, 8);
    chk({tag, "_product"}, product, exp);
    chk({tag, "_busy_cycles"}, busy_cycles, 8);
    chk({tag, "_busy_done_overlap"}, overlap, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, done, 1'b0);
    chk({tag, "_product_hold"}, product, exp);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = 8'h00;
    multiplier   = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_product", product, 16'h0000);
    rst = 1'b0;

    run_mult(8'h03, 8'h05, 16'h000F, "m3x5");

    // Abort a multiply with reset after four RUN edges.
    @(negedge clk);
    multiplicand = 8'h03;
    multiplier   = 8'h05;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_product", product, 16'h0000);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    chk("midrst_idle_busy", busy, 1'b0);

    run_mult(8'hFF, 8'hFF, 16'h0001, "neg1xneg1");
    run_mult(8'h00, 8'h7F, 16'h0000, "zerox127");
    run_mult(8'h80, 8'h80, 16'h4000, "neg128xneg128");
    run_mult(8'h7F, 8'h80, 16'hC080, "m127xneg128");
    run_mult(8'h80, 8'h7F, 16'hC080, "neg128x127");

    // start held while busy must be ignored; start in the done cycle is accepted.
    @(negedge clk);
    multiplicand = 8'h02;
    multiplier   = 8'h09;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    start        = 1'b1;
    multiplicand = 8'h11;
    multiplier   = 8'h22;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("ignore_busy_before_done", busy, 1'b1);
    @(posedge clk);
    #1;
    chk("ignore_done", done, 1'b1);
    chk("ignore_product", product, 16'h0012);
    multiplicand = 8'h06;
    multiplier   = 8'hF9;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done_low", done, 1'b0);
    chk("b2b_product_hold", product, 16'h0012);
    wait_done(lat, busy_cycles, overlap);
    chk("b2b_latency", lat, 8);
    chk("b2b_product", product, 16'hFFD6);
    chk("b2b_busy_cycles", busy_cycles, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
